// File: rtl/sqrl_uart_pkg.sv
// Shared types and constants for the sqrl UART transmit/receive paths.
// Optional even-parity framing is enabled with SQRL_UART_TX_PARITY_EN.
package sqrl_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int DATA_BITS = 8;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // A 2-cycle bit still needs one counter bit.
    function automatic int baud_cnt_width(input int clks);
        return (clks < 2) ? 1 : $clog2(clks);
    endfunction

    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sqrl_uart_baud_cnt.sv
// Bit-period down-counter; bit_done marks the last clk of each bit.
// Shared by the transmit serialiser and the receive-side sampler.
module sqrl_uart_baud_cnt
    import sqrl_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_done
);

    localparam int CNT_W = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Parks at zero between bits so it can never wrap mid-bit.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = (cnt_q == '0);

endmodule

// File: rtl/sqrl_uart_tx.sv
// UART transmitter: valid/ready bytes to 8N1 frames, LSB first.
// Define SQRL_UART_TX_PARITY_EN for 8E1 framing (even parity bit).
module sqrl_uart_tx
    import sqrl_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_tx,
    output logic                 busy
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("sqrl_uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("sqrl_uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);

`ifdef SQRL_UART_TX_PARITY_EN
    localparam uart_state_e AFTER_DATA = PARITY;
`else
    localparam uart_state_e AFTER_DATA = STOP;
`endif

    uart_state_e          state_q;
    uart_state_e          state_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [BIT_IDX_W-1:0] bit_idx_q;
    logic [BIT_IDX_W-1:0] bit_idx_d;
    logic                 stop_idx_q;
    logic                 stop_idx_d;
    logic                 uart_tx_q;
    logic                 uart_tx_d;

    logic bit_done;
    logic restart;
    logic accept;
    logic last_stop;

    sqrl_uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .bit_done(bit_done)
    );

    assign last_stop = (stop_idx_q == STOP_LAST);
    assign tx_ready  = (state_q == IDLE)
                     || (state_q == STOP && bit_done && last_stop);
    assign accept    = tx_valid && tx_ready;
    assign busy      = (state_q != IDLE);
    assign uart_tx   = uart_tx_q;

`ifdef SQRL_UART_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= even_parity(tx_data);
        end
    end
`endif

    // The line flop follows the state one clk later, so the start bit
    // falls on the edge after the byte is accepted.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        uart_tx_d  = LINE_IDLE;

        unique case (state_q)
            IDLE: begin
                uart_tx_d = LINE_IDLE;
            end
            START: begin
                uart_tx_d = LINE_START;
                if (bit_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                uart_tx_d = shift_q[0];
                if (bit_done) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d    = AFTER_DATA;
                        stop_idx_d = 1'b0;
                    end
                end
            end
`ifdef SQRL_UART_TX_PARITY_EN
            PARITY: begin
                uart_tx_d = parity_q;
                if (bit_done) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                uart_tx_d = LINE_IDLE;
                if (bit_done) begin
                    if (last_stop) begin
                        state_d = IDLE;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept wins over STOP->IDLE, giving gapless back-to-back frames.
        if (accept) begin
            state_d    = START;
            shift_d    = tx_data;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
        end

        restart = accept
                || (state_q != IDLE && bit_done && state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            uart_tx_q  <= LINE_IDLE;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            uart_tx_q  <= uart_tx_d;
        end
    end

endmodule

// File: tb/tb_sqrl_uart_tx.sv
// Scoreboard bench for sqrl_uart_tx: a serial receive model pops
// expected bytes; honours SQRL_UART_TX_PARITY_EN when defined.
module tb_sqrl_uart_tx;

`ifdef SQRL_UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    localparam int CPB_A   = 4;
    localparam int STOP_A  = 1;
    localparam int CPB_B   = 5;
    localparam int STOP_B  = 2;
    localparam int FRAME_A = (10 + STOP_A - 1 + PAR) * CPB_A;
    localparam int FRAME_B = (10 + STOP_B - 1 + PAR) * CPB_B;
    localparam int N_RAND  = 500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int frames_b = 0;

    logic       rst_a, rst_b;
    logic [7:0] d_a, d_b;
    logic       vld_a, vld_b;
    logic       rdy_a, rdy_b;
    logic       line_a, line_b;
    logic       busy_a, busy_b;
    logic       abort_a = 1'b1;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    sqrl_uart_tx #(.CLKS_PER_BIT(CPB_A), .STOP_BITS(STOP_A)) dut_a (
        .clk(clk), .reset(rst_a), .tx_data(d_a), .tx_valid(vld_a),
        .tx_ready(rdy_a), .uart_tx(line_a), .busy(busy_a)
    );

    sqrl_uart_tx #(.CLKS_PER_BIT(CPB_B), .STOP_BITS(STOP_B)) dut_b (
        .clk(clk), .reset(rst_b), .tx_data(d_b), .tx_valid(vld_b),
        .tx_ready(rdy_b), .uart_tx(line_b), .busy(busy_b)
    );

    task automatic check_eq(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic rdy_of(input int id);
        return (id == 0) ? rdy_a : rdy_b;
    endfunction

    function automatic logic line_of(input int id);
        return (id == 0) ? line_a : line_b;
    endfunction

    function automatic logic busy_of(input int id);
        return (id == 0) ? busy_a : busy_b;
    endfunction

    task automatic drive(input int id, input logic [7:0] d, input logic v);
        if (id == 0) begin
            d_a = d; vld_a = v;
        end else begin
            d_b = d; vld_b = v;
        end
    endtask

    // Expected line for DUT A, k negedges after the accept edge.
    function automatic logic exp_line_a(input int k, input logic [7:0] b);
        int slot;
        if (k == 0) return 1'b1;
        slot = (k - 1) / CPB_A;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (PAR == 1 && slot == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic send(input int id, input logic [7:0] b, input bit keep,
                        input bit push, input bit scramble, output int acc);
        int n;
        n   = 0;
        acc = 0;
        drive(id, b, 1'b1);
        while (!rdy_of(id) && n < 2000) begin
            if (scramble) drive(id, 8'($urandom), 1'b1);
            @(negedge clk);
            n++;
        end
        drive(id, b, 1'b1);
        if (n >= 2000) begin
            check_eq("send ready timeout", n, 0);
            drive(id, b, 1'b0);
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (push) begin
            if (id == 0) q0.push_back(b);
            else q1.push_back(b);
        end
        if (!keep) drive(id, ~b, 1'b0);
    endtask

    task automatic wait_idle(input int id, output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy_of(id)) break;
            n++;
        end
    endtask

    task automatic watch_a(input logic [7:0] b, output int nb, output int nr,
                           output int rp, output int nl, output logic ps);
        nb = 0; nr = 0; rp = 0; nl = 0; ps = 1'b0;
        for (int k = 0; k < 4 * FRAME_A; k++) begin
            @(negedge clk);
            if (line_a !== exp_line_a(k, b)) nl++;
            if (k == 1 + 9 * CPB_A) ps = line_a;
            if (!busy_a) break;
            nb++;
            if (rdy_a) begin
                nr++;
                rp = nb;
            end
        end
    endtask

    // Serial receive model: frames the line, then scores against the queue.
    task automatic rx_monitor(input int id);
        int cpb, frame, slot, pos;
        logic [7:0] b, e;
        logic ok, par, ln, aborted, ab;
        cpb   = (id == 0) ? CPB_A : CPB_B;
        frame = (id == 0) ? FRAME_A : FRAME_B;
        forever begin
            @(negedge clk);
            ab = (id == 0) ? abort_a : 1'b0;
            if (ab || line_of(id) !== 1'b0) continue;
            ok = 1'b1; b = '0; par = 1'b0; aborted = 1'b0;
            for (int k = 0; k < frame; k++) begin
                if (k > 0) @(negedge clk);
                ab = (id == 0) ? abort_a : 1'b0;
                if (ab) begin
                    aborted = 1'b1;
                    break;
                end
                ln   = line_of(id);
                slot = k / cpb;
                pos  = k % cpb;
                if (slot == 0) begin
                    if (ln !== 1'b0) ok = 1'b0;
                end else if (slot <= 8) begin
                    if (pos == 0) b[slot-1] = ln;
                    else if (ln !== b[slot-1]) ok = 1'b0;
                end else if (PAR == 1 && slot == 9) begin
                    if (pos == 0) par = ln;
                    else if (ln !== par) ok = 1'b0;
                end else if (ln !== 1'b1) begin
                    ok = 1'b0;
                end
            end
            if (aborted) continue;
            if (PAR == 1 && par !== ^b) ok = 1'b0;
            if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                check_eq(id == 0 ? "rx_a unexpected frame" : "rx_b unexpected frame",
                         int'(b), -1);
            end else begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                check_eq(id == 0 ? "rx_a byte" : "rx_b byte", int'(b), int'(e));
                check_eq(id == 0 ? "rx_a frame shape" : "rx_b frame shape",
                         int'(ok), 1);
                if (id == 1) frames_b++;
            end
        end
    endtask

    task automatic run_a();
        int nb, nr, rp, nl, c0, c1, n, acc, bad;
        logic ps;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (line_a !== 1'b1 || rdy_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        check_eq("idle 100 cycles", bad, 0);

        send(0, 8'h55, 1'b0, 1'b1, 1'b0, acc);
        watch_a(8'h55, nb, nr, rp, nl, ps);
        check_eq("0x55 busy cycles", nb, FRAME_A);
        check_eq("0x55 ready count", nr, 1);
        check_eq("0x55 ready position", rp, FRAME_A);
        check_eq("0x55 line waveform errors", nl, 0);

        send(0, 8'hA3, 1'b1, 1'b1, 1'b0, c0);
        send(0, 8'h0F, 1'b0, 1'b1, 1'b0, c1);
        check_eq("b2b accept spacing", c1 - c0, FRAME_A);
        wait_idle(0, n);
        check_eq("b2b total busy", (c1 - c0) + n, 2 * FRAME_A);

        @(negedge clk);
        send(0, 8'hFF, 1'b0, 1'b0, 1'b0, acc);
        repeat (17) @(posedge clk);
        #1;
        abort_a = 1'b1;
        rst_a   = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midframe reset uart_tx", int'(line_a), 1);
        check_eq("midframe reset tx_ready", int'(rdy_a), 1);
        check_eq("midframe reset busy", int'(busy_a), 0);
        rst_a = 1'b0;
        @(negedge clk);
        abort_a = 1'b0;

        send(0, 8'h12, 1'b0, 1'b1, 1'b0, acc);
        watch_a(8'h12, nb, nr, rp, nl, ps);
        check_eq("0x12 busy cycles", nb, FRAME_A);
        check_eq("0x12 line waveform errors", nl, 0);

`ifdef SQRL_UART_TX_PARITY_EN
        send(0, 8'h07, 1'b0, 1'b1, 1'b0, acc);
        watch_a(8'h07, nb, nr, rp, nl, ps);
        check_eq("0x07 parity bit", int'(ps), 1);
        check_eq("0x07 frame cycles", nb, 44);
        send(0, 8'h03, 1'b0, 1'b1, 1'b0, acc);
        watch_a(8'h03, nb, nr, rp, nl, ps);
        check_eq("0x03 parity bit", int'(ps), 0);
        check_eq("0x03 line waveform errors", nl, 0);
`endif
        repeat (6) @(negedge clk);
    endtask

    task automatic run_b();
        int acc, n;
        logic [7:0] b;
        for (int i = 0; i < N_RAND; i++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            b = 8'($urandom);
            send(1, b, 1'b0, 1'b1, 1'b1, acc);
        end
        wait_idle(1, n);
        repeat (8) @(negedge clk);
        check_eq("rx_b frame count", frames_b, N_RAND);
    endtask

    initial rx_monitor(0);
    initial rx_monitor(1);

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        d_a = '0; d_b = '0;
        vld_a = 1'b0; vld_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check_eq("reset uart_tx A", int'(line_a), 1);
        check_eq("reset tx_ready A", int'(rdy_a), 1);
        check_eq("reset busy A", int'(busy_a), 0);
        check_eq("reset uart_tx B", int'(line_b), 1);
        check_eq("reset tx_ready B", int'(rdy_b), 1);
        check_eq("reset busy B", int'(busy_b), 0);
        abort_a = 1'b0;
        fork
            run_a();
            run_b();
        join
        check_eq("queue A drained", q0.size(), 0);
        check_eq("queue B drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sqrl_uart_tx.md
Name: sqrl_uart_tx

Overview:
- UART transmitter: serialises bytes from a valid/ready stream onto a single line as 8N1 frames (optionally 8E1).
- It is the transmit-side counterpart to the UART receive path, which does metastability protection, majority-vote filtering and deserialisation.
- Sits between the host-response logic and the board TX pin, in the same clock domain as the rest of the UART logic.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per bit (100 MHz / 115200). Legal range ≥ 2.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to send, LSB transmitted first.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  the block accepts tx_data this cycle.
- uart_tx  output  1  serial line, idle high, registered output.
- busy  output  1  a frame is in progress (any state other than IDLE).

Behaviour:
- Reset values: uart_tx=1, tx_ready=1, busy=0, state=IDLE, counters=0.
- Reset mid-frame: on the next edge, uart_tx=1 and state=IDLE; the in-flight byte is dropped with no retry.
- Handshake: a byte is accepted on any edge where tx_valid & tx_ready.
  - tx_data is captured into a shift register.
  - tx_data may change after acceptance.
  - tx_valid may be held high without tx_ready; nothing happens.
- tx_ready is high in IDLE and during the last clk of the final stop bit. It is low at all other times.
- States and transitions:
  - IDLE: uart_tx=1. On accept -> START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: uart_tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; 8 bits, tracked by a 3-bit bit index -> PARITY if enabled, else STOP.
  - PARITY: optional; see Optional Feature.
  - STOP: uart_tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
    - If a byte is accepted on the last cycle -> START (back-to-back).
    - Otherwise -> IDLE.
- Latency: uart_tx falls on the first edge after the accept edge.
- Timing:
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - One frame is (10 + STOP_BITS - 1)*CLKS_PER_BIT cycles.
  - Back-to-back frames leave no idle gap.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Loaded with CLKS_PER_BIT-1 on each bit start; counts down; a bit ends at 0.
  - It must not wrap mid-bit.
- Glitch-free line: uart_tx is driven only from a flop, never combinationally.
- Parameter checks: an elaboration-time check fails if CLKS_PER_BIT<2 or STOP_BITS is not 1 or 2.

Optional Feature:
- Macro: SQRL_UART_TX_PARITY_EN.
- When defined:
  - PARITY state inserted between DATA and STOP.
  - uart_tx = XOR of the 8 captured data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame length grows by CLKS_PER_BIT.
  - Parity is computed from the byte at capture and held in a 1-bit register.
- When undefined: no PARITY state and no parity register; the frame is 8N1.

Decomposition:
- Shared package sqrl_uart_pkg:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - DATA_BITS=8.
  - Line level constants LINE_IDLE=1, LINE_START=0.
- Sub-module sqrl_uart_baud_cnt:
  - Parameter CLKS_PER_BIT; inputs clk, reset, restart; output bit_done.
  - Pulses bit_done on the final cycle of each bit period.
  - Reusable by the receive-side sampler.

Test Plan:
- CLKS_PER_BIT=4, send 0x55:
  - uart_tx low cycles 1-4, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles.
  - tx_ready high only on the last stop cycle; busy high 40 cycles total.
- CLKS_PER_BIT=4, tx_valid held high with 0xA3 then 0x0F:
  - Two frames back-to-back, 80 cycles total, no idle cycle between them.
  - The receive model decodes 0xA3, 0x0F.
- Assert reset during DATA bit 3 of 0xFF:
  - Next edge uart_tx=1, tx_ready=1, busy=0.
  - The following send of 0x12 is framed correctly from START.
- tx_valid low for 100 cycles after reset: uart_tx stays 1, tx_ready stays 1, busy stays 0.
- With SQRL_UART_TX_PARITY_EN, CLKS_PER_BIT=4:
  - 0x07 gives parity bit 1; 0x03 gives parity bit 0.
  - Frame = 44 cycles.
- Random test: CLKS_PER_BIT=5, STOP_BITS=2, 500 random bytes with random tx_valid gaps.
  - Scoreboard matches every byte.
  - Each stop period is 10 cycles high.
  - No transfer is accepted while tx_ready is low.
